// File: rtl/wb_commit_queue.sv
// Write-back commit queue: in-order FIFO of MEM-stage results, retiring GPR/CSR writes and exception/ertn reports.
// Latency: push-to-commit one cycle minimum; the head commits combinationally in the cycle it is eligible.
// Backpressure: ws_allowin = ws_count < DEPTH from registered state; the head stalls on a GPR write while rf_ready is low.
// Optional trace port: define WB_TRACE_EN to drive debug_wb_*; otherwise those outputs are tied to 0.
module wb_commit_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic              ms_gr_we,
  input  logic [4:0]        ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic [31:0]       ms_pc,
  input  logic [78:0]       ms_csr_bus,
  input  logic              ms_ex,
  input  logic [5:0]        ms_ecode,
  input  logic [8:0]        ms_esubcode,
  input  logic              ms_ertn,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              csr_we,
  output logic [13:0]       csr_wnum,
  output logic [31:0]       csr_wdata,
  output logic [31:0]       csr_wmask,
  output logic              wb_ex,
  output logic              wb_ertn_flush,
  output logic [31:0]       wb_pc,
  output logic [DATA_W-1:0] wb_badv,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       ws_busy_mask,
  output logic [$clog2(DEPTH):0] ws_count,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic [31:0]       pc;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_wmask;
    logic              ex;
    logic [5:0]        ecode;
    logic [8:0]        esubcode;
    logic              ertn;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  entry_t            w_in;
  entry_t            w_head;
  logic              w_nonempty;
  logic              w_commit;
  logic              w_flush;
  logic              w_push;
  logic [31:0]       w_busy;

  // Pack the incoming MEM-stage instruction; csr bus is {we, num, wdata, wmask}.
  always_comb begin
    w_in.gr_we     = ms_gr_we;
    w_in.dest      = ms_dest;
    w_in.result    = ms_result;
    w_in.pc        = ms_pc;
    w_in.csr_we    = ms_csr_bus[78];
    w_in.csr_num   = ms_csr_bus[77:64];
    w_in.csr_wdata = ms_csr_bus[63:32];
    w_in.csr_wmask = ms_csr_bus[31:0];
    w_in.ex        = ms_ex;
    w_in.ecode     = ms_ecode;
    w_in.esubcode  = ms_esubcode;
    w_in.ertn      = ms_ertn;
  end

  // Head eligibility: only a pending GPR write of a non-excepting entry waits on the register file.
  always_comb begin
    w_head     = r_mem[r_head];
    w_nonempty = (r_count != '0);
    w_commit   = w_nonempty && (!w_head.gr_we || w_head.ex || rf_ready);
    w_flush    = w_commit && (w_head.ex || w_head.ertn);
    ws_allowin = (r_count < CNT_W'(DEPTH));
    w_push     = ms_to_ws_valid && ws_allowin && !w_flush;
  end

  // Scoreboard of pending GPR destinations; r0 never reported busy.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && r_mem[i].gr_we) w_busy[r_mem[i].dest] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  // Pointer, count and valid-bit update; a flushing commit empties the queue and swallows any push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_commit) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_commit);
    end
  end

  // Entry payload needs no reset: it is only observed through valid bits and the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_in;
  end

  assign ws_count      = r_count;
  assign ws_busy_mask  = w_busy;
  assign rf_we         = w_commit && w_head.gr_we && !w_head.ex;
  assign rf_waddr      = w_head.dest;
  assign rf_wdata      = w_head.result;
  assign csr_we        = w_commit && w_head.csr_we && !w_head.ex && !w_head.ertn;
  assign csr_wnum      = w_head.csr_num;
  assign csr_wdata     = w_head.csr_wdata;
  assign csr_wmask     = w_head.csr_wmask;
  assign wb_ex         = w_commit && w_head.ex;
  assign wb_ertn_flush = w_commit && w_head.ertn;
  assign wb_pc         = w_head.pc;
  assign wb_badv       = w_head.result;
  assign wb_ecode      = w_head.ecode;
  assign wb_esubcode   = w_head.esubcode;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = w_head.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_we    = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: a DEPTH=2 instance for most scenarios and a
// DEPTH=4 instance for the flush-with-younger-entries case. Inputs change on the
// falling edge; outputs are sampled 1ns later.
module tb_wb_commit_queue;

  logic        clk;
  logic        reset;
  logic        sel4;
  logic        ms_valid;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic [31:0] ms_pc;
  logic [78:0] ms_csr_bus;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_ertn;
  logic        rf_ready;
  logic        v2, v4;

  // DEPTH=2 instance outputs
  logic        allowin, rf_we, csr_we, wb_ex, wb_ertn;
  logic [4:0]  rf_waddr, dbg_wnum;
  logic [31:0] rf_wdata, csr_wdata, csr_wmask, wb_pc, wb_badv, busy, dbg_pc, dbg_wdata;
  logic [13:0] csr_wnum;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esub;
  logic [1:0]  count;
  logic [3:0]  dbg_we;

  // DEPTH=4 instance outputs
  logic        q_allowin, q_rf_we, q_csr_we, q_wb_ex, q_wb_ertn;
  logic [4:0]  q_rf_waddr, q_dbg_wnum;
  logic [31:0] q_rf_wdata, q_csr_wdata, q_csr_wmask, q_wb_pc, q_wb_badv, q_busy, q_dbg_pc, q_dbg_wdata;
  logic [13:0] q_csr_wnum;
  logic [5:0]  q_wb_ecode;
  logic [8:0]  q_wb_esub;
  logic [2:0]  q_count;
  logic [3:0]  q_dbg_we;

  int nvec = 0;
  int nerr = 0;

  assign v2 = ms_valid & ~sel4;
  assign v4 = ms_valid & sel4;

  wb_commit_queue #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(v2), .ws_allowin(allowin),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
    .ms_csr_bus(ms_csr_bus), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_ertn(ms_ertn), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wdata(csr_wdata),
    .csr_wmask(csr_wmask), .wb_ex(wb_ex), .wb_ertn_flush(wb_ertn), .wb_pc(wb_pc),
    .wb_badv(wb_badv), .wb_ecode(wb_ecode), .wb_esubcode(wb_esub), .ws_busy_mask(busy),
    .ws_count(count), .debug_wb_pc(dbg_pc), .debug_wb_rf_we(dbg_we),
    .debug_wb_rf_wnum(dbg_wnum), .debug_wb_rf_wdata(dbg_wdata)
  );

  wb_commit_queue #(.DATA_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .ms_to_ws_valid(v4), .ws_allowin(q_allowin),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
    .ms_csr_bus(ms_csr_bus), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_ertn(ms_ertn), .rf_ready(rf_ready), .rf_we(q_rf_we), .rf_waddr(q_rf_waddr),
    .rf_wdata(q_rf_wdata), .csr_we(q_csr_we), .csr_wnum(q_csr_wnum), .csr_wdata(q_csr_wdata),
    .csr_wmask(q_csr_wmask), .wb_ex(q_wb_ex), .wb_ertn_flush(q_wb_ertn), .wb_pc(q_wb_pc),
    .wb_badv(q_wb_badv), .wb_ecode(q_wb_ecode), .wb_esubcode(q_wb_esub), .ws_busy_mask(q_busy),
    .ws_count(q_count), .debug_wb_pc(q_dbg_pc), .debug_wb_rf_we(q_dbg_we),
    .debug_wb_rf_wnum(q_dbg_wnum), .debug_wb_rf_wdata(q_dbg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_in();
    ms_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0; ms_pc = 0;
    ms_csr_bus = '0; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0; ms_ertn = 0;
  endtask

  task automatic push_gpr(input logic [4:0] d, input logic [31:0] r);
    clr_in();
    ms_valid = 1; ms_gr_we = 1; ms_dest = d; ms_result = r; ms_pc = 32'h1C00_0000 + {27'd0, d};
  endtask

  task automatic test_reset();
    reset = 1; sel4 = 0; rf_ready = 0; clr_in();
    @(negedge clk); #1;
    nvec++; if (count !== 2'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
    nvec++; if (allowin !== 1'b1) begin nerr++; $display("FAIL reset_allowin got %b want 1", allowin); end
    nvec++; if (busy !== 32'h0) begin nerr++; $display("FAIL reset_busy got %h want 0", busy); end
    nvec++; if ({rf_we, csr_we, wb_ex, wb_ertn} !== 4'b0) begin nerr++; $display("FAIL reset_strobes got %b want 0000", {rf_we, csr_we, wb_ex, wb_ertn}); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_single_commit();
    @(negedge clk); push_gpr(5'd5, 32'h1234_5678); rf_ready = 1; #1;
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL single_empty_rfwe got %b want 0", rf_we); end
    @(negedge clk); clr_in(); #1;
    nvec++; if (rf_we !== 1'b1) begin nerr++; $display("FAIL single_rfwe got %b want 1", rf_we); end
    nvec++; if (rf_waddr !== 5'd5) begin nerr++; $display("FAIL single_waddr got %0d want 5", rf_waddr); end
    nvec++; if (rf_wdata !== 32'h1234_5678) begin nerr++; $display("FAIL single_wdata got %h want 12345678", rf_wdata); end
    nvec++; if (busy !== 32'h0000_0020) begin nerr++; $display("FAIL single_busy got %h want 00000020", busy); end
`ifdef WB_TRACE_EN
    nvec++; if (dbg_we !== 4'hF) begin nerr++; $display("FAIL single_dbg_we got %h want f", dbg_we); end
`else
    nvec++; if (dbg_we !== 4'h0) begin nerr++; $display("FAIL single_dbg_we got %h want 0", dbg_we); end
`endif
    @(negedge clk); #1;
    nvec++; if (count !== 2'd0) begin nerr++; $display("FAIL single_count got %0d want 0", count); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL single_idle_rfwe got %b want 0", rf_we); end
  endtask

  task automatic test_backpressure();
    rf_ready = 0;
    @(negedge clk); push_gpr(5'd3, 32'hAAAA_0003); #1;
    @(negedge clk); push_gpr(5'd7, 32'hBBBB_0007); #1;
    nvec++; if (count !== 2'd1) begin nerr++; $display("FAIL bp_count1 got %0d want 1", count); end
    nvec++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL bp_stall_rfwe got %b want 0", rf_we); end
    // queue full: this offer must be refused
    @(negedge clk); push_gpr(5'd9, 32'h9999_0009); #1;
    nvec++; if (count !== 2'd2) begin nerr++; $display("FAIL bp_count2 got %0d want 2", count); end
    nvec++; if (allowin !== 1'b0) begin nerr++; $display("FAIL bp_allowin got %b want 0", allowin); end
    nvec++; if (busy !== 32'h0000_0088) begin nerr++; $display("FAIL bp_busy got %h want 00000088", busy); end
    @(negedge clk); clr_in(); rf_ready = 1; #1;
    nvec++; if (count !== 2'd2) begin nerr++; $display("FAIL bp_refused got %0d want 2", count); end
    nvec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA_0003) begin nerr++; $display("FAIL bp_first got we=%b a=%0d d=%h want 1/3/aaaa0003", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk); #1;
    nvec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB_0007) begin nerr++; $display("FAIL bp_second got we=%b a=%0d d=%h want 1/7/bbbb0007", rf_we, rf_waddr, rf_wdata); end
    nvec++; if (busy !== 32'h0000_0080) begin nerr++; $display("FAIL bp_busy2 got %h want 00000080", busy); end
    @(negedge clk); #1;
    nvec++; if (count !== 2'd0 || rf_we !== 1'b0) begin nerr++; $display("FAIL bp_drain got cnt=%0d we=%b want 0/0", count, rf_we); end
  endtask

  task automatic test_exception_flush();
    sel4 = 1; rf_ready = 0;
    @(negedge clk); push_gpr(5'd2, 32'h0000_0022); #1;
    @(negedge clk); clr_in(); ms_valid = 1; ms_ex = 1; ms_ecode = 6'h08; ms_esubcode = 9'h001;
      ms_gr_we = 1; ms_dest = 5'd4; ms_result = 32'hDEAD_0000; ms_pc = 32'h1C00_0040; #1;
    nvec++; if (q_count !== 3'd1) begin nerr++; $display("FAIL ex_count1 got %0d want 1", q_count); end
    @(negedge clk); push_gpr(5'd6, 32'h0000_0066); #1;
    @(negedge clk); push_gpr(5'd9, 32'h0000_0099); rf_ready = 1; #1;
    nvec++; if (q_count !== 3'd3) begin nerr++; $display("FAIL ex_count3 got %0d want 3", q_count); end
    nvec++; if (q_busy !== 32'h0000_0054) begin nerr++; $display("FAIL ex_busy got %h want 00000054", q_busy); end
    nvec++; if (q_rf_we !== 1'b1 || q_rf_waddr !== 5'd2 || q_wb_ex !== 1'b0) begin nerr++; $display("FAIL ex_older got we=%b a=%0d ex=%b want 1/2/0", q_rf_we, q_rf_waddr, q_wb_ex); end
    // head is now the excepting entry with two younger entries behind it, plus a same-cycle offer
    @(negedge clk); push_gpr(5'd10, 32'h0000_00AA); #1;
    nvec++; if (q_wb_ex !== 1'b1) begin nerr++; $display("FAIL ex_pulse got %b want 1", q_wb_ex); end
    nvec++; if (q_wb_ecode !== 6'h08 || q_wb_esub !== 9'h001) begin nerr++; $display("FAIL ex_codes got %h/%h want 08/001", q_wb_ecode, q_wb_esub); end
    nvec++; if (q_wb_badv !== 32'hDEAD_0000 || q_wb_pc !== 32'h1C00_0040) begin nerr++; $display("FAIL ex_badv_pc got %h/%h want dead0000/1c000040", q_wb_badv, q_wb_pc); end
    nvec++; if (q_rf_we !== 1'b0 || q_csr_we !== 1'b0) begin nerr++; $display("FAIL ex_writes got rf=%b csr=%b want 0/0", q_rf_we, q_csr_we); end
    @(negedge clk); clr_in(); #1;
    nvec++; if (q_count !== 3'd0) begin nerr++; $display("FAIL ex_flush_count got %0d want 0", q_count); end
    nvec++; if (q_wb_ex !== 1'b0 || q_rf_we !== 1'b0) begin nerr++; $display("FAIL ex_after got ex=%b rf=%b want 0/0", q_wb_ex, q_rf_we); end
    nvec++; if (q_busy !== 32'h0) begin nerr++; $display("FAIL ex_busy_clr got %h want 0", q_busy); end
    sel4 = 0;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_a [5];
    logic [31:0] exp_d [5];
    exp_a[0] = 5'd1; exp_d[0] = 32'h0000_00A1;
    exp_a[1] = 5'd2; exp_d[1] = 32'h0000_00B2;
    exp_a[2] = 5'd3; exp_d[2] = 32'h0000_00C3;
    exp_a[3] = 5'd4; exp_d[3] = 32'h0000_00D4;
    exp_a[4] = 5'd5; exp_d[4] = 32'h0000_00E5;
    rf_ready = 0;
    @(negedge clk); push_gpr(exp_a[0], exp_d[0]); #1;
    @(negedge clk); push_gpr(exp_a[1], exp_d[1]); #1;
    // full: first commit, offer of entry 2 refused
    @(negedge clk); push_gpr(exp_a[2], exp_d[2]); rf_ready = 1; #1;
    nvec++; if (count !== 2'd2 || allowin !== 1'b0) begin nerr++; $display("FAIL b2b_full got cnt=%0d allow=%b want 2/0", count, allowin); end
    nvec++; if (rf_waddr !== exp_a[0] || rf_wdata !== exp_d[0] || rf_we !== 1'b1) begin nerr++; $display("FAIL b2b_c0 got a=%0d d=%h want %0d/%h", rf_waddr, rf_wdata, exp_a[0], exp_d[0]); end
    // steady state: one push and one commit per cycle, head/tail wrap each cycle
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) push_gpr(exp_a[k+1], exp_d[k+1]); else clr_in();
      #1;
      nvec++; if (count !== 2'd1) begin nerr++; $display("FAIL b2b_count%0d got %0d want 1", k, count); end
      nvec++; if (rf_we !== 1'b1 || rf_waddr !== exp_a[k] || rf_wdata !== exp_d[k]) begin nerr++; $display("FAIL b2b_c%0d got we=%b a=%0d d=%h want 1/%0d/%h", k, rf_we, rf_waddr, rf_wdata, exp_a[k], exp_d[k]); end
    end
    @(negedge clk); clr_in(); #1;
    nvec++; if (count !== 2'd0 || rf_we !== 1'b0) begin nerr++; $display("FAIL b2b_drain got cnt=%0d we=%b want 0/0", count, rf_we); end
  endtask

  task automatic test_csr_ertn();
    rf_ready = 1;
    @(negedge clk); clr_in(); ms_valid = 1; ms_pc = 32'h1C00_0070;
      ms_csr_bus = {1'b1, 14'h0006, 32'hCAFE_F00D, 32'hFFFF_FFFF}; #1;
    @(negedge clk); clr_in(); ms_valid = 1; ms_ertn = 1; ms_pc = 32'h1C00_0080;
      ms_csr_bus = {1'b1, 14'h0007, 32'h1111_1111, 32'h0000_00FF}; #1;
    nvec++; if (csr_we !== 1'b1) begin nerr++; $display("FAIL csr_we got %b want 1", csr_we); end
    nvec++; if (csr_wnum !== 14'h6 || csr_wdata !== 32'hCAFE_F00D || csr_wmask !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL csr_fields got %h/%h/%h want 0006/cafef00d/ffffffff", csr_wnum, csr_wdata, csr_wmask); end
    nvec++; if (wb_ertn !== 1'b0 || rf_we !== 1'b0) begin nerr++; $display("FAIL csr_side got ertn=%b rf=%b want 0/0", wb_ertn, rf_we); end
    @(negedge clk); clr_in(); #1;
    nvec++; if (wb_ertn !== 1'b1 || csr_we !== 1'b0) begin nerr++; $display("FAIL ertn got flush=%b csr=%b want 1/0", wb_ertn, csr_we); end
    nvec++; if (wb_pc !== 32'h1C00_0080 || wb_ex !== 1'b0) begin nerr++; $display("FAIL ertn_pc got pc=%h ex=%b want 1c000080/0", wb_pc, wb_ex); end
    @(negedge clk); #1;
    nvec++; if (wb_ertn !== 1'b0 || count !== 2'd0) begin nerr++; $display("FAIL ertn_after got flush=%b cnt=%0d want 0/0", wb_ertn, count); end
  endtask

  task automatic test_async_reset();
    rf_ready = 0;
    @(negedge clk); push_gpr(5'd11, 32'h0000_0B0B); #1;
    @(negedge clk); push_gpr(5'd12, 32'h0000_0C0C); #1;
    @(negedge clk); clr_in(); #1;
    nvec++; if (count !== 2'd2) begin nerr++; $display("FAIL ar_pre got %0d want 2", count); end
    // without reset, raising rf_ready would commit entry 11 right now
    rf_ready = 1; #1; reset = 1; #1;
    nvec++; if (count !== 2'd0 || allowin !== 1'b1) begin nerr++; $display("FAIL ar_state got cnt=%0d allow=%b want 0/1", count, allowin); end
    nvec++; if (rf_we !== 1'b0 || csr_we !== 1'b0 || busy !== 32'h0) begin nerr++; $display("FAIL ar_outs got rf=%b csr=%b busy=%h want 0/0/0", rf_we, csr_we, busy); end
    @(negedge clk); reset = 0; #1;
    nvec++; if (count !== 2'd0 || rf_we !== 1'b0) begin nerr++; $display("FAIL ar_post got cnt=%0d rf=%b want 0/0", count, rf_we); end
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_backpressure();
    test_exception_flush();
    test_back_to_back();
    test_csr_ertn();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
